// File: rtl/uart_tx_word_serializer.sv
// rtl/uart_tx_word_serializer.sv - word FIFO plus MSB-first byte serializer feeding uart_tx.
// Optional inter-word idle gap enabled by defining UART_TX_GAP_EN.
module uart_tx_word_serializer #(
  parameter int REG_SIZE   = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLE  = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [REG_SIZE-1:0]         word_data,
  input  logic                        word_valid,
  output logic                        word_ready,
  output logic [7:0]                  tx_data,
  output logic                        tx_data_valid,
  input  logic                        tx_data_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy,
  output logic                        overflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int NBYTES = REG_SIZE / 8;
  localparam int BC_W   = $clog2(NBYTES + 1);
  localparam logic [BC_W-1:0]  LAST_IDX = BC_W'(NBYTES - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  if ((REG_SIZE < 8) || ((REG_SIZE % 8) != 0) || (FIFO_DEPTH < 2) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (GAP_CYCLE < 1)) begin : g_param_check
    $error("uart_tx_word_serializer: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    count_q, count_d;
  logic [REG_SIZE-1:0] shift_q, shift_d;
  logic [BC_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic                busy_q, busy_d;
  logic                overflow_q, overflow_d;
  logic [REG_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic                push;
  logic                pop;

`ifdef UART_TX_GAP_EN
  localparam int GAP_W = $clog2(GAP_CYCLE + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLE - 1);
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
`endif

  assign word_ready    = (count_q != FULL_LVL);
  assign tx_data_valid = (state_q == ST_SEND);
  assign tx_data       = shift_q[REG_SIZE-1 -: 8];
  assign fifo_level    = count_q;
  assign busy          = busy_q;
  assign overflow      = overflow_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    overflow_d = overflow_q;
    pop        = 1'b0;
    push       = word_valid && word_ready;
`ifdef UART_TX_GAP_EN
    gap_cnt_d  = gap_cnt_q;
`endif

    // A full FIFO rejects the write even if the FSM frees a slot this cycle.
    if (word_valid && !word_ready) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          shift_d    = mem_q[rd_ptr_q];
          byte_cnt_d = LAST_IDX;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_data_ready) begin
          shift_d = shift_q << 8;
          if (byte_cnt_q == '0) begin
`ifdef UART_TX_GAP_EN
            gap_cnt_d = GAP_LAST;
            state_d   = ST_GAP;
`else
            state_d   = ST_IDLE;
`endif
          end else begin
            byte_cnt_d = byte_cnt_q - BC_W'(1);
          end
        end
      end
`ifdef UART_TX_GAP_EN
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + LVL_W'(push) - LVL_W'(pop);
    busy_d   = (count_d != '0) || (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef UART_TX_GAP_EN
      gap_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
`ifdef UART_TX_GAP_EN
      gap_cnt_q  <= gap_cnt_d;
`endif
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= word_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_word_serializer.sv
// tb/tb_uart_tx_word_serializer.sv - self-checking bench for uart_tx_word_serializer.
module tb_uart_tx_word_serializer;
  localparam int RS = 32;
  localparam int FD = 8;
  localparam int GC = 20;
`ifdef UART_TX_GAP_EN
  localparam int GAP_EXP = GC;
`else
  localparam int GAP_EXP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [RS-1:0] word_data = '0;
  logic          word_valid = 1'b0;
  logic          word_ready;
  logic [7:0]    tx_data;
  logic          tx_data_valid;
  logic          tx_data_ready = 1'b0;
  logic [$clog2(FD):0] fifo_level;
  logic          busy;
  logic          overflow;

  uart_tx_word_serializer #(.REG_SIZE(RS), .FIFO_DEPTH(FD), .GAP_CYCLE(GC)) dut (
    .clk(clk), .rst(rst), .word_data(word_data), .word_valid(word_valid),
    .word_ready(word_ready), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
    .tx_data_ready(tx_data_ready), .fifo_level(fifo_level), .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference: queue of stored words, byte queue of the word in flight, idle countdown.
  logic [RS-1:0] m_q[$];
  logic [7:0]    m_cur[$];
  logic [7:0]    exp_stream[$];
  logic [7:0]    got[$];
  int            m_gap = 0;
  bit            m_ovf = 1'b0;
  int            n_checks = 0;
  int            n_errors = 0;

  function automatic bit m_busy();
    return (m_q.size() != 0) || (m_cur.size() != 0) || (m_gap != 0);
  endfunction

  task automatic cycle();
    bit acc;
    logic [RS-1:0] w;
    if (tx_data_valid && tx_data_ready && !rst) got.push_back(tx_data);
    if (rst) begin
      m_q.delete(); m_cur.delete(); m_gap = 0; m_ovf = 1'b0;
    end else begin
      acc = word_valid && (m_q.size() != FD);
      if (word_valid && !acc) m_ovf = 1'b1;
      if (m_cur.size() != 0) begin
        if (tx_data_ready) begin
          void'(m_cur.pop_front());
          if (m_cur.size() == 0) m_gap = GAP_EXP;
        end
      end else if (m_gap != 0) begin
        m_gap--;
      end else if (m_q.size() != 0) begin
        w = m_q.pop_front();
        for (int b = 0; b < RS / 8; b++) m_cur.push_back(w[RS-1-8*b -: 8]);
      end
      if (acc) begin
        m_q.push_back(word_data);
        for (int b = 0; b < RS / 8; b++) exp_stream.push_back(word_data[RS-1-8*b -: 8]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; word_valid = 1'b0; tx_data_ready = 1'b0;
    cycle(); cycle();
    n_checks++; if (fifo_level !== 4'd0) begin n_errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    n_checks++; if (word_ready !== 1'b1) begin n_errors++; $display("FAIL reset_word_ready got %b exp 1", word_ready); end
    n_checks++; if (tx_data_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b exp 0", tx_data_valid); end
    n_checks++; if (tx_data !== 8'h00) begin n_errors++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_single_word();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h12; exp_b[1] = 8'h34; exp_b[2] = 8'h56; exp_b[3] = 8'h78;
    got.delete();
    tx_data_ready = 1'b1; word_data = 32'h12345678; word_valid = 1'b1;
    cycle();
    word_valid = 1'b0;
    n_checks++; if (tx_data_valid !== 1'b0) begin n_errors++; $display("FAIL single_valid_n1 got %b exp 0", tx_data_valid); end
    n_checks++; if (fifo_level !== 4'd1) begin n_errors++; $display("FAIL single_level_n1 got %0d exp 1", fifo_level); end
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++;
      if (tx_data_valid !== 1'b1 || tx_data !== exp_b[i]) begin
        n_errors++; $display("FAIL single_byte%0d got v=%b %h exp v=1 %h", i, tx_data_valid, tx_data, exp_b[i]);
      end
    end
    cycle();
    n_checks++; if (tx_data_valid !== 1'b0) begin n_errors++; $display("FAIL single_valid_end got %b exp 0", tx_data_valid); end
    n_checks++; if (busy !== m_busy()) begin n_errors++; $display("FAIL single_busy_end got %b exp %b", busy, m_busy()); end
    n_checks++; if (fifo_level !== 4'd0) begin n_errors++; $display("FAIL single_level_end got %0d exp 0", fifo_level); end
    while (m_busy()) cycle();
  endtask

  task automatic test_handshake_toggle();
    bit pat [6];
    int k = 0;
    bit pv, pa;
    logic [7:0] pd;
    logic [7:0] exp_b [4];
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 0; pat[5] = 1;
    exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3; exp_b[3] = 8'hD4;
    got.delete();
    tx_data_ready = 1'b0; word_data = 32'hA1B2C3D4; word_valid = 1'b1;
    cycle();
    word_valid = 1'b0;
    for (int t = 0; t < 10 && !tx_data_valid; t++) cycle();
    while (got.size() < 4 && k < 40) begin
      tx_data_ready = (k < 6) ? pat[k] : 1'b1;
      pv = tx_data_valid; pd = tx_data; pa = pv && tx_data_ready;
      cycle();
      k++;
      if (pv && !pa) begin
        n_checks++;
        if (tx_data_valid !== 1'b1 || tx_data !== pd) begin
          n_errors++; $display("FAIL hold_stable got v=%b %h exp v=1 %h", tx_data_valid, tx_data, pd);
        end
      end
    end
    n_checks++; if (got.size() != 4) begin n_errors++; $display("FAIL handshake_count got %0d exp 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_checks++; if (got[i] !== exp_b[i]) begin n_errors++; $display("FAIL handshake_byte%0d got %h exp %h", i, got[i], exp_b[i]); end
    end
    tx_data_ready = 1'b1;
    for (int t = 0; t < 60 && m_busy(); t++) cycle();
  endtask

  task automatic test_overflow_full_pop();
    int t = 0;
    int de_seen = 0;
    got.delete(); exp_stream.delete();
    tx_data_ready = 1'b0;
    // One word sits in the shift register, so nine pushes are needed to fill the FIFO.
    for (int i = 0; i < 9; i++) begin
      word_data = 32'(i); word_valid = 1'b1;
      cycle();
    end
    n_checks++; if (fifo_level !== 4'd8) begin n_errors++; $display("FAIL full_level got %0d exp 8", fifo_level); end
    n_checks++; if (word_ready !== 1'b0) begin n_errors++; $display("FAIL full_word_ready got %b exp 0", word_ready); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL full_ovf_early got %b exp 0", overflow); end
    word_data = 32'hDEADBEEF;
    cycle();
    word_valid = 1'b0;
    n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL drop_overflow got %b exp 1", overflow); end
    n_checks++; if (fifo_level !== 4'd8) begin n_errors++; $display("FAIL drop_level got %0d exp 8", fifo_level); end
    tx_data_ready = 1'b1;
    while ((m_cur.size() != 0 || m_gap != 0) && t < 80) begin cycle(); t++; end
    word_data = 32'hBAD0BAD0; word_valid = 1'b1;
    cycle();
    word_valid = 1'b0;
    n_checks++; if (fifo_level !== 4'd7) begin n_errors++; $display("FAIL pop_push_level got %0d exp 7", fifo_level); end
    n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL pop_push_overflow got %b exp 1", overflow); end
    t = 0;
    while ((m_busy() || busy) && t < 600) begin cycle(); t++; end
    n_checks++; if (got.size() != 36) begin n_errors++; $display("FAIL full_stream_len got %0d exp 36", got.size()); end
    for (int i = 0; i < got.size() && i < 36; i++) begin
      n_checks++;
      if (got[i] !== 8'((i % 4 == 3) ? i / 4 : 0)) begin
        n_errors++; $display("FAIL full_stream_byte%0d got %h exp %h", i, got[i], 8'((i % 4 == 3) ? i / 4 : 0));
      end
      if (got[i] == 8'hDE || got[i] == 8'hBA) de_seen++;
    end
    n_checks++; if (de_seen != 0) begin n_errors++; $display("FAIL dropped_word_sent got %0d exp 0", de_seen); end
  endtask

  task automatic test_reset_mid_word();
    int t = 0;
    got.delete();
    tx_data_ready = 1'b0;
    word_data = 32'hCAFEF00D; word_valid = 1'b1; cycle();
    for (int i = 1; i < 4; i++) begin word_data = 32'(i * 32'h01010101); cycle(); end
    word_valid = 1'b0;
    tx_data_ready = 1'b1;
    while (got.size() < 2 && t < 20) begin cycle(); t++; end
    rst = 1'b1; tx_data_ready = 1'b0;
    cycle();
    rst = 1'b0; tx_data_ready = 1'b1;
    n_checks++; if (tx_data_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_valid got %b exp 0", tx_data_valid); end
    n_checks++; if (fifo_level !== 4'd0) begin n_errors++; $display("FAIL midrst_level got %0d exp 0", fifo_level); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL midrst_overflow got %b exp 0", overflow); end
    for (int i = 0; i < 20; i++) cycle();
    n_checks++; if (got.size() != 2) begin n_errors++; $display("FAIL midrst_bytes got %0d exp 2", got.size()); end
    n_checks++; if (got.size() >= 2 && (got[0] !== 8'hCA || got[1] !== 8'hFE)) begin
      n_errors++; $display("FAIL midrst_order got %h %h exp ca fe", got[0], got[1]);
    end
  endtask

  task automatic test_back_to_back_gap();
    int t = 0;
    int low = 0;
    got.delete();
    tx_data_ready = 1'b1;
    word_data = 32'h11223344; word_valid = 1'b1; cycle();
    word_data = 32'h55667788; cycle();
    word_valid = 1'b0;
    while (got.size() < 4 && t < 40) begin cycle(); t++; end
    while (!tx_data_valid && low < 100) begin
      n_checks++;
      if (busy !== 1'b1) begin n_errors++; $display("FAIL gap_busy got %b exp 1 at idle cycle %0d", busy, low); end
      low++; cycle();
    end
    n_checks++; if (low != GAP_EXP + 1) begin n_errors++; $display("FAIL word_gap got %0d exp %0d", low, GAP_EXP + 1); end
    n_checks++; if (tx_data !== 8'h55) begin n_errors++; $display("FAIL gap_next_byte got %h exp 55", tx_data); end
    t = 0;
    while (m_busy() && t < 80) begin cycle(); t++; end
  endtask

  task automatic test_random();
    int t = 0;
    rst = 1'b1; cycle(); rst = 1'b0;
    got.delete(); exp_stream.delete();
    for (int c = 0; c < 800; c++) begin
      word_valid = ($urandom_range(0, 2) == 0);
      word_data = $urandom;
      tx_data_ready = ($urandom_range(0, 3) != 0);
      cycle();
      n_checks++;
      if (tx_data_valid !== (m_cur.size() != 0) || fifo_level !== 4'(m_q.size()) ||
          word_ready !== (m_q.size() != FD) || busy !== m_busy() || overflow !== m_ovf ||
          (tx_data_valid && m_cur.size() != 0 && tx_data !== m_cur[0])) begin
        n_errors++;
        $display("FAIL random_cycle%0d got v=%b d=%h l=%0d r=%b b=%b o=%b exp v=%b l=%0d b=%b o=%b",
                 c, tx_data_valid, tx_data, fifo_level, word_ready, busy, overflow,
                 m_cur.size() != 0, m_q.size(), m_busy(), m_ovf);
      end
    end
    word_valid = 1'b0; tx_data_ready = 1'b1;
    while ((m_busy() || busy) && t < 800) begin cycle(); t++; end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL random_drain_timeout got busy=%b exp 0", busy); end
    n_checks++; if (got.size() != exp_stream.size()) begin n_errors++; $display("FAIL random_stream_len got %0d exp %0d", got.size(), exp_stream.size()); end
    for (int i = 0; i < got.size() && i < exp_stream.size(); i++) begin
      n_checks++; if (got[i] !== exp_stream[i]) begin n_errors++; $display("FAIL random_byte%0d got %h exp %h", i, got[i], exp_stream[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_handshake_toggle();
    test_overflow_full_pop();
    test_reset_mid_word();
    test_back_to_back_gap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
